// File: rtl/im2col_row_feeder_pkg.sv
// -----------------------------------------------------------------------------
// feeder_pkg
// Shared definitions for the im2col row feeder:
//   - feeder_state_t : pass-control FSM states
//   - cnt_width()    : width of a counter that indexes 0..n-1 (minimum 1 bit)
// -----------------------------------------------------------------------------
package feeder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_LAST,
        DRAIN,
        DONE
    } feeder_state_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/im2col_row_feeder_row_fifo.sv
// -----------------------------------------------------------------------------
// row_fifo
// Synchronous first-word-fall-through FIFO holding whole assembled rows.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (flushes contents)
//   push       : write push_data this cycle (accepted when not full, or when
//                a pop happens in the same cycle)
//   push_data  : row to write
//   pop        : remove the head entry (ignored when empty)
//   head       : current head entry (undefined when empty)
//   full/empty : occupancy flags
//   count      : number of stored entries
// -----------------------------------------------------------------------------
module row_fifo import feeder_pkg::*; #(
    parameter int unsigned WIDTH = 288,
    parameter int unsigned DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              push,
    input  logic [WIDTH-1:0]                  push_data,
    input  logic                              pop,
    output logic [WIDTH-1:0]                  head,
    output logic                              full,
    output logic                              empty,
    output logic [cnt_width(DEPTH+1)-1:0]     count
);

    localparam int unsigned PW = cnt_width(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CNT_DEPTH);
    assign pop_ok  = pop && !empty;
    // A full FIFO can still take a row when the head leaves on the same edge.
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/im2col_row_feeder.sv
// -----------------------------------------------------------------------------
// im2col_row_feeder
// Streams an M x N im2col matrix from word-addressed memory to a systolic
// array input, one full row per transfer, with valid/ready back-pressure.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (aborts a pass)
//   start         : one-cycle pulse, starts a pass when idle
//   busy          : pass in progress (FETCH / WAIT_LAST / DRAIN)
//   done          : one-cycle pulse after the last row has been accepted
//   rd_en/addr_rd : memory read request and word address
//   data_rd       : read data, one cycle after rd_en
//   x_out         : row vector, element j at [(j+1)*DATA_WIDTH-1 : j*DATA_WIDTH]
//   x_valid       : x_out holds a row
//   x_ready       : consumer accepts the row this cycle
//   row_idx       : index of the row on x_out
//   stall_cycles  : (FEEDER_STALL_CNT_EN only) valid-but-not-ready cycles in
//                   the current/last pass, saturating
// Build option: define FEEDER_STALL_CNT_EN to add the stall_cycles counter.
// -----------------------------------------------------------------------------
module im2col_row_feeder import feeder_pkg::*; #(
    parameter int unsigned            M          = 20,
    parameter int unsigned            N          = 9,
    parameter int unsigned            DATA_WIDTH = 32,
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  SRC_BASE   = ADDR_WIDTH'(32'h0000_2000),
    parameter int unsigned            ROW_STRIDE = N,
    parameter int unsigned            FIFO_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      rd_en,
    output logic [ADDR_WIDTH-1:0]     addr_rd,
    input  logic [DATA_WIDTH-1:0]     data_rd,
    output logic [DATA_WIDTH*N-1:0]   x_out,
    output logic                      x_valid,
    input  logic                      x_ready,
    output logic [$clog2(M)-1:0]      row_idx
`ifdef FEEDER_STALL_CNT_EN
    ,
    output logic [31:0]               stall_cycles
`endif
);

    localparam int unsigned CW = cnt_width(N);
    localparam int unsigned RW = cnt_width(M);
    localparam int unsigned FW = cnt_width(FIFO_DEPTH + 1);
    localparam logic [CW-1:0]         COL_LAST = CW'(N - 1);
    localparam logic [RW-1:0]         ROW_LAST = RW'(M - 1);
    localparam logic [ADDR_WIDTH-1:0] STRIDE_A = ADDR_WIDTH'(ROW_STRIDE);

    feeder_state_t state, state_next;

    logic [CW-1:0]           col;
    logic [RW-1:0]           row;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH-1:0]   row_base;
    logic [FW-1:0]           in_flight;
    logic                    cap_valid;
    logic [CW-1:0]           cap_col;
    logic [DATA_WIDTH*N-1:0] asm_data;
    logic                    asm_done;
    logic [RW-1:0]           out_row;
    logic                    last_taken;

    logic                    start_ok;
    logic                    row_open;
    logic                    row_begin;
    logic                    last_read;
    logic                    xfer;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic [FW-1:0]           fifo_count;
    logic [DATA_WIDTH*N-1:0] fifo_head;

    assign start_ok  = (state == IDLE) && start;
    assign row_begin = rd_en && (col == '0);
    assign last_read = rd_en && (row == ROW_LAST) && (col == COL_LAST);
    assign xfer      = x_valid && x_ready;

    // A new row is committed only if a FIFO slot is guaranteed for it, counting
    // rows still being assembled as already occupying a slot.
    always_comb begin
        row_open = !fifo_full &&
                   ((32'(fifo_count) + 32'(in_flight)) < FIFO_DEPTH);
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (start)     state_next = FETCH;
            FETCH:     if (last_read) state_next = WAIT_LAST;
            WAIT_LAST:                state_next = DRAIN;
            DRAIN:     if (fifo_empty && last_taken) state_next = DONE;
            DONE:                     state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        rd_en = 1'b0;
        case (state)
            FETCH: begin
                busy  = 1'b1;
                // Mid-row reads always continue; only row starts are gated.
                rd_en = (col != '0) || row_open;
            end
            WAIT_LAST: busy = 1'b1;
            DRAIN:     busy = 1'b1;
            DONE:      done = 1'b1;
            default:   ;
        endcase
    end

    // ---------------- Fetch, assembly and output bookkeeping ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            addr_q     <= '0;
            row_base   <= '0;
            in_flight  <= '0;
            cap_valid  <= 1'b0;
            cap_col    <= '0;
            asm_data   <= '0;
            asm_done   <= 1'b0;
            out_row    <= '0;
            last_taken <= 1'b0;
        end else begin
            if (start_ok) begin
                col        <= '0;
                row        <= '0;
                addr_q     <= SRC_BASE;
                row_base   <= SRC_BASE;
                in_flight  <= '0;
                out_row    <= '0;
                last_taken <= 1'b0;
            end else begin
                // Address is tracked incrementally: +1 within a row, and the
                // next row base on wrap; it holds after the final read.
                if (rd_en) begin
                    if (col == COL_LAST) begin
                        col <= '0;
                        if (row == ROW_LAST) begin
                            row <= '0;
                        end else begin
                            row      <= row + 1'b1;
                            row_base <= row_base + STRIDE_A;
                            addr_q   <= row_base + STRIDE_A;
                        end
                    end else begin
                        col    <= col + 1'b1;
                        addr_q <= addr_q + 1'b1;
                    end
                end
                in_flight <= in_flight + FW'(row_begin) - FW'(asm_done);
                if (xfer) begin
                    out_row <= (out_row == ROW_LAST) ? '0 : out_row + 1'b1;
                    if (out_row == ROW_LAST) begin
                        last_taken <= 1'b1;
                    end
                end
            end

            cap_valid <= rd_en;
            cap_col   <= col;
            for (int unsigned j = 0; j < N; j++) begin
                if (cap_valid && (cap_col == CW'(j))) begin
                    asm_data[j*DATA_WIDTH +: DATA_WIDTH] <= data_rd;
                end
            end
            // Row is pushed on the edge after its last element lands.
            asm_done <= cap_valid && (cap_col == COL_LAST);
        end
    end

    row_fifo #(
        .WIDTH (DATA_WIDTH * N),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (asm_done),
        .push_data (asm_data),
        .pop       (xfer),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign x_valid = !fifo_empty;
    assign x_out   = x_valid ? fifo_head : '0;
    assign addr_rd = addr_q;
    assign row_idx = out_row;

`ifdef FEEDER_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (start_ok) begin
            stall_cycles <= '0;
        end else if (busy && x_valid && !x_ready && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_im2col_row_feeder.sv
// -----------------------------------------------------------------------------
// tb_im2col_row_feeder
// Two feeders (row stride 9 and row stride 12) share stimulus and a word
// memory model; a reference model derives every expected address, row vector
// and stall count directly from the memory contents and stride.
// -----------------------------------------------------------------------------
module tb_im2col_row_feeder;

    localparam int M  = 20;
    localparam int N  = 9;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic x_ready;

    logic            busy_a, done_a, rd_en_a, x_valid_a;
    logic [31:0]     addr_a;
    logic [31:0]     data_a = '0;
    logic [N*DW-1:0] x_out_a;
    logic [4:0]      row_idx_a;
    logic            busy_b, done_b, rd_en_b, x_valid_b;
    logic [31:0]     addr_b;
    logic [31:0]     data_b = '0;
    logic [N*DW-1:0] x_out_b;
    logic [4:0]      row_idx_b;
`ifdef FEEDER_STALL_CNT_EN
    logic [31:0]     stall_a, stall_b;
`endif

    im2col_row_feeder #(
        .M(M), .N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(32),
        .SRC_BASE(32'h0000_2000), .ROW_STRIDE(9), .FIFO_DEPTH(2)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start), .busy(busy_a), .done(done_a),
        .rd_en(rd_en_a), .addr_rd(addr_a), .data_rd(data_a),
        .x_out(x_out_a), .x_valid(x_valid_a), .x_ready(x_ready),
        .row_idx(row_idx_a)
`ifdef FEEDER_STALL_CNT_EN
        , .stall_cycles(stall_a)
`endif
    );

    im2col_row_feeder #(
        .M(M), .N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(32),
        .SRC_BASE(32'h0000_2000), .ROW_STRIDE(12), .FIFO_DEPTH(2)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start), .busy(busy_b), .done(done_b),
        .rd_en(rd_en_b), .addr_rd(addr_b), .data_rd(data_b),
        .x_out(x_out_b), .x_valid(x_valid_b), .x_ready(x_ready),
        .row_idx(row_idx_b)
`ifdef FEEDER_STALL_CNT_EN
        , .stall_cycles(stall_b)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    int stride [2] = '{9, 12};

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    int  rd_cnt   [2];
    int  xfer_cnt [2];
    int  done_cnt [2];
    int  stall_m  [2];
    int  last_xfer[2];
    int  ncyc = 0;
    bit  mon_en = 1'b0;
    bit  spacing_chk = 1'b0;

    logic        pend_en_a = 1'b0, pend_en_b = 1'b0;
    logic [31:0] pend_addr_a = '0, pend_addr_b = '0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] idx;
        idx = a - 32'h0000_2000;
        if (idx < 32'd256) return mem[idx[7:0]];
        return 32'hBAD0_0BAD;
    endfunction

    // Row r as the consumer should see it: N consecutive words from the row start.
    function automatic logic [N*DW-1:0] exp_row(input int r, input int s);
        logic [N*DW-1:0] v;
        for (int j = 0; j < N; j++) v[j*DW +: DW] = mem[r*s + j];
        return v;
    endfunction

    // Memory answers exactly one cycle after the request.
    always @(posedge clk) begin
        data_a <= pend_en_a ? mem_word(pend_addr_a) : 32'hDEAD_BEEF;
        data_b <= pend_en_b ? mem_word(pend_addr_b) : 32'hDEAD_BEEF;
    end

    task automatic mon(input int d, input logic dn, input logic re, input logic [31:0] ad,
                       input logic [N*DW-1:0] xo, input logic xv, input logic [4:0] ri);
        int r, j;
        if (re) begin
            if (rd_cnt[d] < M*N) begin
                r = rd_cnt[d] / N;
                j = rd_cnt[d] % N;
                check($sformatf("addr%0d_r%0d_e%0d", d, r, j), 512'(ad),
                      512'(32'h2000 + r*stride[d] + j));
            end else begin
                check($sformatf("extra_read%0d", d), 512'(rd_cnt[d]), 512'(M*N - 1));
            end
            rd_cnt[d]++;
        end
        if (xv && x_ready) begin
            if (xfer_cnt[d] < M) begin
                check($sformatf("row%0d_data_%0d", d, xfer_cnt[d]), 512'(xo),
                      512'(exp_row(xfer_cnt[d], stride[d])));
                check($sformatf("row%0d_idx_%0d", d, xfer_cnt[d]), 512'(ri), 512'(xfer_cnt[d]));
                if (spacing_chk && xfer_cnt[d] > 0)
                    check($sformatf("row%0d_spacing", d), 512'(ncyc - last_xfer[d]), 512'(N));
            end else begin
                check($sformatf("extra_xfer%0d", d), 512'(xfer_cnt[d]), 512'(M - 1));
            end
            last_xfer[d] = ncyc;
            xfer_cnt[d]++;
        end
        if (!xv) check($sformatf("xout_zero%0d", d), 512'(xo), 512'(0));
        if (xv && !x_ready) stall_m[d]++;
        if (dn) begin
            check($sformatf("done_after_last%0d", d), 512'(xfer_cnt[d]), 512'(M));
            done_cnt[d]++;
        end
    endtask

    always @(negedge clk) begin
        pend_en_a   = rd_en_a;
        pend_addr_a = addr_a;
        pend_en_b   = rd_en_b;
        pend_addr_b = addr_b;
        if (mon_en) begin
            mon(0, done_a, rd_en_a, addr_a, x_out_a, x_valid_a, row_idx_a);
            mon(1, done_b, rd_en_b, addr_b, x_out_b, x_valid_b, row_idx_b);
        end
        ncyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_pass();
        for (int d = 0; d < 2; d++) begin
            rd_cnt[d] = 0; xfer_cnt[d] = 0; done_cnt[d] = 0;
            stall_m[d] = 0; last_xfer[d] = 0;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy_a"},  512'(busy_a), 512'(0));
        check({tag, "_done_a"},  512'(done_a), 512'(0));
        check({tag, "_rden_a"},  512'(rd_en_a), 512'(0));
        check({tag, "_addr_a"},  512'(addr_a), 512'(0));
        check({tag, "_valid_a"}, 512'(x_valid_a), 512'(0));
        check({tag, "_xout_a"},  512'(x_out_a), 512'(0));
        check({tag, "_ridx_a"},  512'(row_idx_a), 512'(0));
        check({tag, "_busy_b"},  512'(busy_b), 512'(0));
        check({tag, "_done_b"},  512'(done_b), 512'(0));
        check({tag, "_rden_b"},  512'(rd_en_b), 512'(0));
        check({tag, "_addr_b"},  512'(addr_b), 512'(0));
        check({tag, "_valid_b"}, 512'(x_valid_b), 512'(0));
        check({tag, "_xout_b"},  512'(x_out_b), 512'(0));
        check({tag, "_ridx_b"},  512'(row_idx_b), 512'(0));
    endtask

    // mode 0: ready high, 1: random, 2: toggling, 3: held low 40 cycles after first valid
    task automatic run_pass(input int mode, input int restart_at);
        int cyc;
        int fv;
        new_pass();
        fv = -1;
        start = 1'b1;
        x_ready = (mode != 3);
        tick();
        start = 1'b0;
        check("busy_after_start_a", 512'(busy_a), 512'(1));
        check("busy_after_start_b", 512'(busy_b), 512'(1));
`ifdef FEEDER_STALL_CNT_EN
        check("stall_clear_a", 512'(stall_a), 512'(0));
        check("stall_clear_b", 512'(stall_b), 512'(0));
`endif
        cyc = 0;
        while (!(done_cnt[0] > 0 && done_cnt[1] > 0) && cyc < 3000) begin
            if (fv < 0 && x_valid_a) begin
                fv = cyc;
                check("first_valid_latency", 512'(fv), 512'(N + 2));
            end
            if (mode == 3 && fv >= 0 && cyc == fv + 20) begin
                check("hold_row0_a", 512'(x_out_a), 512'(exp_row(0, 9)));
                check("hold_row0_b", 512'(x_out_b), 512'(exp_row(0, 12)));
            end
            if (mode == 3 && fv >= 0 && cyc == fv + 40) begin
                check("hold_reads_a", 512'(rd_cnt[0]), 512'(2*N));
                check("hold_reads_b", 512'(rd_cnt[1]), 512'(2*N));
                check("hold_rden_a",  512'(rd_en_a), 512'(0));
                check("hold_valid_a", 512'(x_valid_a), 512'(1));
                check("hold_end_row0_a", 512'(x_out_a), 512'(exp_row(0, 9)));
                check("hold_ridx_a",  512'(row_idx_a), 512'(0));
            end
            start = (cyc == restart_at);
            case (mode)
                0:       x_ready = 1'b1;
                1:       x_ready = 1'($urandom_range(0, 1));
                2:       x_ready = (cyc % 2 == 0);
                default: x_ready = (fv >= 0 && cyc >= fv + 40);
            endcase
            tick();
            cyc++;
        end
        start = 1'b0;
        check("pass_finished", 512'(cyc < 3000), 512'(1));
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("xfers%0d", d), 512'(xfer_cnt[d]), 512'(M));
            check($sformatf("dones%0d", d), 512'(done_cnt[d]), 512'(1));
            check($sformatf("reads%0d", d), 512'(rd_cnt[d]), 512'(M*N));
        end
        check("idle_after_a", 512'(busy_a), 512'(0));
        check("idle_after_b", 512'(busy_b), 512'(0));
`ifdef FEEDER_STALL_CNT_EN
        check("stall_count_a", 512'(stall_a), 512'(stall_m[0]));
        check("stall_count_b", 512'(stall_b), 512'(stall_m[1]));
`endif
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        start = 1'b0;
        x_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 32'(i);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_idle("reset");
        mon_en = 1'b1;

        // Linear memory contents, consumer always ready: rows every N cycles.
        spacing_chk = 1'b1;
        run_pass(0, -1);
        spacing_chk = 1'b0;

        // Consumer holds off for 40 cycles after the first row appears.
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        run_pass(3, -1);

        // Reset in the middle of row 7, then a clean pass.
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        new_pass();
        start = 1'b1;
        x_ready = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (rd_cnt[0] < 7*N + 4 && cyc < 500) begin
            tick();
            cyc++;
        end
        check("reached_row7", 512'(rd_cnt[0] >= 7*N + 4), 512'(1));
        rst = 1'b1;
        tick();
        check_idle("midpass_reset");
        rst = 1'b0;
        repeat (30) tick();
        check("no_done_after_abort_a", 512'(done_cnt[0]), 512'(0));
        check("no_done_after_abort_b", 512'(done_cnt[1]), 512'(0));
        check("idle_after_abort_a", 512'(busy_a), 512'(0));
        run_pass(1, -1);

        // Second start in the 5th busy cycle must be ignored.
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        run_pass(1, 4);

        // Toggling ready exercises the stall counter; the next pass clears it.
        run_pass(2, -1);
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        run_pass(1, -1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
